// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel 3x3 window generator.
// Window slots are numbered row-major: top row 0..2, centre row 3..5, bottom row 6..8.
package sobel_pkg;

    localparam int DEF_IMG_W = 512;
    localparam int DEF_IMG_H = 512;
    localparam int DEF_PIX_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int P_TL  = 0;
    localparam int P_TC  = 1;
    localparam int P_TR  = 2;
    localparam int P_ML  = 3;
    localparam int P_MC  = 4;
    localparam int P_MR  = 5;
    localparam int P_BL  = 6;
    localparam int P_BC  = 7;
    localparam int P_BR  = 8;
    localparam int WIN_N = 9;

    // One bit per window slot: 1 keeps the pixel, 0 forces it to zero at a border.
    function automatic logic [WIN_N-1:0] border_keep(
        input logic top,
        input logic bot,
        input logic left,
        input logic right
    );
        logic [WIN_N-1:0] keep;
        keep = '1;
        if (top) begin
            keep[P_TL] = 1'b0;
            keep[P_TC] = 1'b0;
            keep[P_TR] = 1'b0;
        end
        if (bot) begin
            keep[P_BL] = 1'b0;
            keep[P_BC] = 1'b0;
            keep[P_BR] = 1'b0;
        end
        if (left) begin
            keep[P_TL] = 1'b0;
            keep[P_ML] = 1'b0;
            keep[P_BL] = 1'b0;
        end
        if (right) begin
            keep[P_TR] = 1'b0;
            keep[P_MR] = 1'b0;
            keep[P_BR] = 1'b0;
        end
        return keep;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// DEPTH-entry delay line: o_dout is the value written DEPTH enabled cycles earlier.
// Storage is not reset; the window generator masks any stale entries.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;

    // Read-before-write on the same slot gives exactly DEPTH shifts of delay.
    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream in, one zero-padded 3x3 neighbourhood out per pixel (p0..p8).
// Two line buffers supply the upper rows; a FLUSH phase drains the last W+1 windows.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             win_last,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(NPIX);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
    localparam logic [IDX_W-1:0] PRIME_IDX = IDX_W'(IMG_W + 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic             r_in_en;
    logic [IDX_W-1:0] r_in_idx;
    logic [ROW_W-1:0] r_orow;
    logic [COL_W-1:0] r_ocol;

    logic w_out_free;
    logic w_accept;
    logic w_fire;
    logic w_shift;
    logic w_load;
    logic w_load_last;

    logic [PIX_W-1:0] w_col_in;
    logic [PIX_W-1:0] w_row1;
    logic [PIX_W-1:0] w_row2;

    logic [WIN_N-1:0]            w_keep;
    logic [WIN_N-1:0][PIX_W-1:0] r_win;
    logic [WIN_N-1:0][PIX_W-1:0] w_win_nxt;
    logic [WIN_N-1:0][PIX_W-1:0] w_win_msk;
    logic [WIN_N-1:0][PIX_W-1:0] r_out;

    assign w_out_free  = !win_valid || win_ready;
    assign in_ready    = r_in_en && (r_state == RUN) && w_out_free;
    assign w_accept    = in_valid && in_ready;
    assign w_fire      = win_valid && win_ready;
    assign w_load_last = (r_orow == LAST_ROW) && (r_ocol == LAST_COL);

    // Controller: RUN shifts on accepts, FLUSH shifts zeros until the last window is loaded.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_col_in    = '0;
        case (r_state)
            RUN: begin
                w_col_in = in_pixel;
                w_shift  = w_accept;
                w_load   = w_accept && (r_in_idx >= PRIME_IDX);
                if (w_accept && (r_in_idx == LAST_IDX)) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_shift = w_out_free && !(win_valid && win_last);
                w_load  = w_shift;
                if (w_fire && win_last) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_in_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_in_en <= 1'b1;
        end
    end

    // Counters wrap to zero at frame end, so FLUSH->RUN leaves them cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_idx <= '0;
            r_orow   <= '0;
            r_ocol   <= '0;
        end else begin
            if (w_accept) begin
                r_in_idx <= (r_in_idx == LAST_IDX) ? '0 : r_in_idx + IDX_W'(1);
            end
            if (w_load) begin
                if (r_ocol == LAST_COL) begin
                    r_ocol <= '0;
                    r_orow <= (r_orow == LAST_ROW) ? '0 : r_orow + ROW_W'(1);
                end else begin
                    r_ocol <= r_ocol + COL_W'(1);
                end
            end
        end
    end

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb_row1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_shift),
        .i_din  (w_col_in),
        .o_dout (w_row1)
    );

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb_row2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_shift),
        .i_din  (w_row1),
        .o_dout (w_row2)
    );

    // New right-hand column: two rows back, one row back, and the incoming pixel.
    always_comb begin
        w_win_nxt       = r_win;
        w_win_nxt[P_TL] = r_win[P_TC];
        w_win_nxt[P_TC] = r_win[P_TR];
        w_win_nxt[P_TR] = w_row2;
        w_win_nxt[P_ML] = r_win[P_MC];
        w_win_nxt[P_MC] = r_win[P_MR];
        w_win_nxt[P_MR] = w_row1;
        w_win_nxt[P_BL] = r_win[P_BC];
        w_win_nxt[P_BC] = r_win[P_BR];
        w_win_nxt[P_BR] = w_col_in;
    end

    always_comb begin
        w_keep = border_keep(r_orow == '0, r_orow == LAST_ROW,
                             r_ocol == '0, r_ocol == LAST_COL);
        for (int i = 0; i < WIN_N; i++) begin
            w_win_msk[i] = w_keep[i] ? w_win_nxt[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_win <= w_win_nxt;
        end
    end

    // Output register: loads take priority, an unloaded fire drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            r_out     <= '0;
        end else if (w_load) begin
            win_valid <= 1'b1;
            win_last  <= w_load_last;
            r_out     <= w_win_msk;
        end else if (w_fire) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

    assign p0 = r_out[P_TL];
    assign p1 = r_out[P_TC];
    assign p2 = r_out[P_TR];
    assign p3 = r_out[P_ML];
    assign p4 = r_out[P_MC];
    assign p5 = r_out[P_MR];
    assign p6 = r_out[P_BL];
    assign p7 = r_out[P_BC];
    assign p8 = r_out[P_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen at W=4, H=3: a reference model queues the
// expected zero-padded windows per frame and a monitor checks every fired window.
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;
    localparam int N  = W * H;

    typedef logic [8:0][PW-1:0] win_t;
    typedef logic [127:0] val_t;
    typedef struct packed {
        win_t data;
        logic last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_pixel = '0;
    logic          win_valid;
    logic          win_ready = 1'b1;
    logic          win_last;
    logic [PW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;

    always #5 clk = ~clk;

    sobel_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last),
        .p0 (p0), .p1 (p1), .p2 (p2), .p3 (p3), .p4 (p4),
        .p5 (p5), .p6 (p6), .p7 (p7), .p8 (p8)
    );

    win_t cur;
    assign cur = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

    exp_t sb_q[$];
    win_t log_w[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   frame_fired = 0;
    int   last_cnt = 0;
    int   stall_seen = 0;
    bit   first_seen = 0;
    bit   prev_stall = 0;
    bit   prev_last_fire = 0;
    win_t prev_win;
    exp_t mon_e;
    int   rdy_mode = 0;
    int   stall_req = 0;

    task automatic check(input bit ok, input string name, input val_t act, input val_t exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic win_t mk9(input int v[9]);
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = PW'(v[i]);
        return w;
    endfunction

    // Reference: every window is the 3x3 neighbourhood of its centre, out-of-frame = 0.
    function automatic void push_frame(input int pix[N]);
        exp_t e;
        int   rr, cc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                            e.data[(dr + 1) * 3 + (dc + 1)] = PW'(pix[rr * W + cc]);
                        else
                            e.data[(dr + 1) * 3 + (dc + 1)] = '0;
                    end
                end
                e.last = (r == H - 1) && (c == W - 1);
                sb_q.push_back(e);
            end
        end
    endfunction

    // Downstream ready generator: steady, scripted stall, or random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: win_ready = 1'b1;
                1: begin
                    if (stall_req > 0) begin
                        win_ready = 1'b0;
                        stall_req = stall_req - 1;
                    end else begin
                        win_ready = 1'b1;
                    end
                end
                default: win_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            log_w.delete();
            acc_cnt        = 0;
            frame_fired    = 0;
            last_cnt       = 0;
            first_seen     = 0;
            prev_stall     = 0;
            prev_last_fire = 0;
        end else begin
            if (prev_stall) begin
                check(win_valid === 1'b1, "stall_valid_hold", val_t'(win_valid), val_t'(1));
                check(cur === prev_win, "stall_data_hold", val_t'(cur), val_t'(prev_win));
            end
            if (prev_last_fire)
                check(in_ready === 1'b1, "ready_after_last", val_t'(in_ready), val_t'(1));
            if (win_valid && !win_ready) begin
                stall_seen++;
                check(in_ready === 1'b0, "stall_in_ready", val_t'(in_ready), val_t'(0));
            end
            if (win_valid && frame_fired >= N - W - 2)
                check(in_ready === 1'b0, "flush_in_ready", val_t'(in_ready), val_t'(0));
            if (win_valid && !first_seen) begin
                first_seen = 1;
                check(acc_cnt == W + 2, "first_window_latency", val_t'(acc_cnt), val_t'(W + 2));
            end
            if (win_valid && win_ready) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_window", val_t'(cur), val_t'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check(cur === mon_e.data, "window_data", val_t'(cur), val_t'(mon_e.data));
                    check(win_last === mon_e.last, "window_last", val_t'(win_last), val_t'(mon_e.last));
                end
                log_w.push_back(cur);
                if (win_last) begin
                    last_cnt++;
                    frame_fired = 0;
                end else begin
                    frame_fired++;
                end
            end
            prev_last_fire = win_valid && win_ready && win_last;
            if (in_valid && in_ready) acc_cnt++;
            prev_stall = win_valid && !win_ready;
            prev_win   = cur;
        end
    end

    // Driver: called and returns aligned 1 time unit after a rising edge.
    task automatic send_frame(input int pix[N], input int n_send, input bit gaps, input int stall_at);
        int guard;
        push_frame(pix);
        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                repeat ($urandom_range(2)) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_pixel = PW'(pix[i]);
            guard = 0;
            while (1) begin
                @(negedge clk);
                if (in_ready) break;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 1000) begin
                    check(1'b0, "accept_timeout", val_t'(i), val_t'(0));
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (i + 1 == stall_at) stall_req = 3;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_windows(input int target);
        int guard;
        guard = 0;
        while (log_w.size() < target) begin
            @(posedge clk);
            guard++;
            if (guard > 2000) begin
                check(1'b0, "drain_timeout", val_t'(log_w.size()), val_t'(target));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int pix_a[N];
    int pix_d[N];
    int pix_g[N];
    int s0;

    initial begin
        for (int i = 0; i < N; i++) begin
            pix_a[i] = i + 1;
            pix_d[i] = i + 101;
            pix_g[i] = int'($urandom_range(255));
        end

        rst_n = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(win_valid === 1'b0, "reset_win_valid", val_t'(win_valid), val_t'(0));
        check(win_last === 1'b0, "reset_win_last", val_t'(win_last), val_t'(0));
        check(in_ready === 1'b0, "reset_in_ready", val_t'(in_ready), val_t'(0));
        check(cur === '0, "reset_window", val_t'(cur), val_t'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous stream, downstream always ready.
        rdy_mode = 0;
        send_frame(pix_a, N, 1'b0, 0);
        wait_windows(N);
        check(log_w.size() == N, "frame_window_count", val_t'(log_w.size()), val_t'(N));
        check(last_cnt == 1, "frame_last_count", val_t'(last_cnt), val_t'(1));
        check(log_w[0] === mk9('{0, 0, 0, 0, 1, 2, 0, 5, 6}), "first_window",
              val_t'(log_w[0]), val_t'(mk9('{0, 0, 0, 0, 1, 2, 0, 5, 6})));
        check(log_w[7] === mk9('{3, 4, 0, 7, 8, 0, 11, 12, 0}), "right_edge_window",
              val_t'(log_w[7]), val_t'(mk9('{3, 4, 0, 7, 8, 0, 11, 12, 0})));
        check(log_w[11] === mk9('{7, 8, 0, 11, 12, 0, 0, 0, 0}), "last_window",
              val_t'(log_w[11]), val_t'(mk9('{7, 8, 0, 11, 12, 0, 0, 0, 0})));

        // Three-cycle downstream stall in mid-frame.
        rdy_mode = 1;
        s0 = stall_seen;
        send_frame(pix_a, N, 1'b0, 8);
        wait_windows(2 * N);
        check(stall_seen - s0 >= 3, "backpressure_applied", val_t'(stall_seen - s0), val_t'(3));

        // Two back-to-back frames with random input gaps and random downstream ready.
        rdy_mode = 2;
        send_frame(pix_a, N, 1'b1, 0);
        send_frame(pix_d, N, 1'b1, 0);
        wait_windows(4 * N);
        check(log_w[3 * N] === mk9('{0, 0, 0, 0, 101, 102, 0, 105, 106}), "second_frame_first",
              val_t'(log_w[3 * N]), val_t'(mk9('{0, 0, 0, 0, 101, 102, 0, 105, 106})));
        check(last_cnt == 4, "b2b_last_count", val_t'(last_cnt), val_t'(4));

        // Random pixel values under random flow control.
        send_frame(pix_g, N, 1'b1, 0);
        wait_windows(5 * N);

        // Reset in the middle of a frame, then a fresh frame.
        rdy_mode = 0;
        send_frame(pix_a, 7, 1'b0, 0);
        check(win_valid === 1'b1, "valid_before_reset", val_t'(win_valid), val_t'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check(win_valid === 1'b0, "async_reset_valid", val_t'(win_valid), val_t'(0));
        check(in_ready === 1'b0, "async_reset_ready", val_t'(in_ready), val_t'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(pix_a, N, 1'b0, 0);
        wait_windows(N);
        check(log_w.size() == N, "post_reset_count", val_t'(log_w.size()), val_t'(N));
        check(last_cnt == 1, "post_reset_last_count", val_t'(last_cnt), val_t'(1));
        check(log_w[0] === mk9('{0, 0, 0, 0, 1, 2, 0, 5, 6}), "post_reset_first",
              val_t'(log_w[0]), val_t'(mk9('{0, 0, 0, 0, 1, 2, 0, 5, 6})));
        check(log_w[7] === mk9('{3, 4, 0, 7, 8, 0, 11, 12, 0}), "post_reset_right_edge",
              val_t'(log_w[7]), val_t'(mk9('{3, 4, 0, 7, 8, 0, 11, 12, 0})));
        check(log_w[11] === mk9('{7, 8, 0, 11, 12, 0, 0, 0, 0}), "post_reset_last",
              val_t'(log_w[11]), val_t'(mk9('{7, 8, 0, 11, 12, 0, 0, 0, 0})));
        check(sb_q.size() == 0, "scoreboard_empty", val_t'(sb_q.size()), val_t'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Producer side of the Sobel kernel's 3x3 window interface.
- Accepts a row-major raster pixel stream, one pixel per handshake, and emits one zero-padded 3x3 neighbourhood per input pixel (W*H windows per frame) in p0..p8 order, ready to drive the sobel datapath.
- Contains two line buffers, a window register array, border masking, and a fill/run/flush controller.

Parameters:
- IMG_W, 512, pixels per row (>=2)
- IMG_H, 512, rows per frame (>=2)
- PIX_W, 8, bits per pixel

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  PIX_W  raster pixel
- win_valid  out  1  window outputs valid
- win_ready  in  1  downstream accepts window
- win_last  out  1  high with the last window of a frame
- p0..p8  out  PIX_W each  window: p0 p1 p2 = row above (left to right), p3 p4 p5 = centre row (p4 = centre pixel), p6 p7 p8 = row below

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values: win_valid=0, win_last=0, p0..p8=0, in_ready=0 while rst_n low. All counters are zero and the state is RUN.
  - Line-buffer contents need no reset, because masking hides stale data.
- Accept and fire conditions:
  - Accept = in_valid && in_ready.
  - Fire = win_valid && win_ready.
- Output register behaviour: registered. win_valid and p0..p8 hold stable while win_valid && !win_ready.
- in_ready = (state==RUN) && (!win_valid || win_ready). No input is taken while an output is stalled.
- Input counter: in_idx counts accepts, 0..W*H-1.
- Output counter: (orow, ocol) gives the centre coordinate of the next window.
- Window timing: the window for centre index k needs input index k+W+1.
  - It is produced when the accept of index k+W+1 occurs.
  - win_valid rises the cycle after that accept.
  - The first window of a frame follows the (W+2)th accept.
- States:
  - RUN: accept input. After the accept of index W*H-1, go to FLUSH.
  - FLUSH: in_ready=0. Emit the remaining W+1 windows, one per cycle when not stalled, using zero for any "future" pixel.
    - When the window with win_last is loaded and later fires, return to RUN with all counters cleared.
  - Frames are back-to-back. No sof/eof input; frame boundaries come from counts only.
- Border masking (applied to outputs; stored data is unaffected):
  - orow==0 zeroes p0,p1,p2.
  - orow==H-1 zeroes p6,p7,p8.
  - ocol==0 zeroes p0,p3,p6.
  - ocol==W-1 zeroes p2,p5,p8.
  - A corner applies both masks.
- Counter wrap: ocol wraps at W-1 and increments orow. win_last=1 exactly when orow==H-1 && ocol==W-1.
- Widths and arithmetic: pure data movement. No arithmetic on pixel values; widths stay PIX_W. The top level zero-extends to the sobel input width.
- Simultaneous events: a fire and a load in the same cycle are legal and give full throughput of 1 window/cycle.
- Reset mid-frame: everything is discarded and the next accepted pixel is treated as (0,0).
- Output count: exactly W*H windows per frame. No window is emitted before its pixels are present.

Decomposition:
- Shared package sobel_pkg holds:
  - the default IMG_W/IMG_H/PIX_W constants
  - the state enum {RUN, FLUSH}
  - window index constants P_TL..P_BR (0..8)
- Sub-module sobel_line_buf: one W-deep PIX_W delay line with write/read on shift-enable. It is instantiated twice, to give row-1 and row-2 taps.

Test Plan:
All scenarios use W=4, H=3, PIX_W=8 and input pixels 1..12 unless noted.
- Reset then stream with win_ready=1, in_valid=1 continuous:
  - First win_valid is the cycle after the 6th accept.
  - Window = 0,0,0,0,1,2,0,5,6.
  - 12 windows total. Exactly one win_last, on the 12th window.
- Interior/right edge: 8th window (centre 8) = 3,4,0,7,8,0,11,12,0.
- Flush: in_ready=0 for the 5 flush windows. The last window = 7,8,0,11,12,0,0,0,0 with win_last=1. in_ready returns 1 the cycle after it fires.
- Backpressure: hold win_ready=0 for 3 cycles mid-frame:
  - p0..p8 and win_valid stay stable.
  - in_ready=0 throughout.
  - No pixel is lost. Output sequence is identical to the unstalled case.
- Random in_valid/win_ready gaps over 2 back-to-back frames (second frame = 101..112): window sequence matches a reference model, and the second frame's first window = 0,0,0,0,101,102,0,105,106.
- Assert rst_n low after 7 accepts:
  - win_valid drops immediately (async).
  - After release, a fresh 1..12 frame reproduces the first scenario exactly.
